// File: rtl/hue_seq_pkg.sv
// Shared types and helpers for the hue sequencer: sector encoding, default
// duty width and the sector/ramp-to-RGB mapping.
package hue_seq_pkg;

    localparam int HUE_DUTY_W_DEF = 8;
    // Internal arithmetic width for the triple helper; callers slice to DUTY_W.
    localparam int HUE_W          = 16;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } sector_t;

    typedef struct packed {
        logic [HUE_W-1:0] r;
        logic [HUE_W-1:0] g;
        logic [HUE_W-1:0] b;
    } hue_rgb_t;

    function automatic hue_rgb_t hue_triple(input sector_t sector,
                                            input logic [HUE_W-1:0] k,
                                            input logic [HUE_W-1:0] max);
        hue_rgb_t t;
        t = '0;
        case (sector)
            S0:      begin t.r = max;     t.g = k;         t.b = '0;      end
            S1:      begin t.r = max - k; t.g = max;       t.b = '0;      end
            S2:      begin t.r = '0;      t.g = max;       t.b = k;       end
            S3:      begin t.r = '0;      t.g = max - k;   t.b = max;     end
            S4:      begin t.r = k;       t.g = '0;        t.b = max;     end
            S5:      begin t.r = max;     t.g = '0;        t.b = max - k; end
            default: begin t.r = max;     t.g = '0;        t.b = '0;      end
        endcase
        return t;
    endfunction

    function automatic sector_t sector_next(input sector_t sector);
        sector_t n;
        case (sector)
            S0:      n = S1;
            S1:      n = S2;
            S2:      n = S3;
            S3:      n = S4;
            S4:      n = S5;
            default: n = S0;
        endcase
        return n;
    endfunction

    function automatic sector_t sector_prev(input sector_t sector);
        sector_t n;
        case (sector)
            S1:      n = S0;
            S2:      n = S1;
            S3:      n = S2;
            S4:      n = S3;
            S5:      n = S4;
            default: n = S5;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/hue_sequencer_step_tick.sv
// step_tick: free-running 0..STEP_DIV-1 prescaler that freezes when en_i=0
// and pulses tick_o for one cycle on each wrap.
module step_tick #(
    parameter int STEP_DIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int                CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick_o = en_i && (cnt_q == LAST);
        cnt_d  = cnt_q;
        if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hue_sequencer.sv
// hue_sequencer: walks hue around R->Y->G->C->B->M and offers one duty triple
// per step on a valid/ready port. Optional macro HUE_SEQ_DIR_EN adds a dir input.
module hue_sequencer
    import hue_seq_pkg::*;
#(
    parameter int CLK_FREQ = 12000000,
    parameter int CYCLE_MS = 1000,
    parameter int DUTY_W   = HUE_DUTY_W_DEF,
    parameter int STEP_DIV = CLK_FREQ / 1000 * CYCLE_MS / (6 * ((1 << DUTY_W) - 1))
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
`ifdef HUE_SEQ_DIR_EN
    input  logic              dir,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DUTY_W-1:0] duty_r,
    output logic [DUTY_W-1:0] duty_g,
    output logic [DUTY_W-1:0] duty_b
);

    // Handshake: a triple transfers on any cycle with out_valid && out_ready;
    // while out_valid is high and out_ready low, duty_* hold steady.

    localparam logic [DUTY_W-1:0] MAX    = '1;
    localparam logic [DUTY_W-1:0] K_LAST = DUTY_W'((1 << DUTY_W) - 2);

    logic tick;
    logic step_back;

    step_tick #(
        .STEP_DIV (STEP_DIV)
    ) u_step_tick (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (en),
        .tick_o (tick)
    );

`ifdef HUE_SEQ_DIR_EN
    assign step_back = dir;
`else
    assign step_back = 1'b0;
`endif

    sector_t           sector_q, sector_d;
    logic [DUTY_W-1:0] k_q, k_d;
    logic              pending_q, pending_d;
    logic              valid_q, valid_d;
    logic [DUTY_W-1:0] r_q, r_d;
    logic [DUTY_W-1:0] g_q, g_d;
    logic [DUTY_W-1:0] b_q, b_d;
    logic              advance;
    hue_rgb_t          trip;
    logic              unused_hi;

    always_comb begin
        sector_d  = sector_q;
        k_d       = k_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        trip      = '0;
        // A fresh tick counts as pending in the same cycle so it can advance at once.
        pending_d = pending_q | tick;
        valid_d   = valid_q & ~out_ready;
        advance   = (pending_q | tick) & (~valid_q | out_ready);

        if (advance) begin
            if (step_back) begin
                if (k_q == '0) begin
                    k_d      = K_LAST;
                    sector_d = sector_prev(sector_q);
                end else begin
                    k_d = k_q - DUTY_W'(1);
                end
            end else begin
                if (k_q == K_LAST) begin
                    k_d      = '0;
                    sector_d = sector_next(sector_q);
                end else begin
                    k_d = k_q + DUTY_W'(1);
                end
            end
            trip      = hue_triple(sector_d, HUE_W'(k_d), HUE_W'(MAX));
            r_d       = trip.r[DUTY_W-1:0];
            g_d       = trip.g[DUTY_W-1:0];
            b_d       = trip.b[DUTY_W-1:0];
            pending_d = 1'b0;
            valid_d   = 1'b1;
        end
    end

    // Upper helper bits are always zero for values bounded by MAX.
    assign unused_hi = ^{trip.r[HUE_W-1:DUTY_W], trip.g[HUE_W-1:DUTY_W],
                         trip.b[HUE_W-1:DUTY_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            sector_q  <= S0;
            k_q       <= '0;
            pending_q <= 1'b0;
            valid_q   <= 1'b0;
            r_q       <= MAX;
            g_q       <= '0;
            b_q       <= '0;
        end else begin
            sector_q  <= sector_d;
            k_q       <= k_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
        end
    end

    assign out_valid = valid_q;
    assign duty_r    = r_q;
    assign duty_g    = g_q;
    assign duty_b    = b_q;

endmodule

// File: tb/tb_hue_sequencer.sv
// Bench for hue_sequencer: two instances (STEP_DIV=4 and STEP_DIV=1) checked
// against a position-based colour-wheel model.
module tb_hue_sequencer;

    localparam int MAXV = 255;
    localparam int REV  = 6 * MAXV;

    logic       clk = 1'b0;
    logic       rst_a, en_a, ready_a, va;
    logic [7:0] ra, ga, ba;
    logic       rst_b, en_b, ready_b, vb;
    logic [7:0] rb, gb, bb;
`ifdef HUE_SEQ_DIR_EN
    logic       dir_a = 1'b0;
    logic       dir_b = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_a = 0;
    int pa    = 0;
    int pb    = 0;
    logic [23:0] prev_b;

    always #5 clk = ~clk;

    hue_sequencer #(.STEP_DIV(4)) dut_a (
        .clk       (clk),
        .rst       (rst_a),
        .en        (en_a),
`ifdef HUE_SEQ_DIR_EN
        .dir       (dir_a),
`endif
        .out_valid (va),
        .out_ready (ready_a),
        .duty_r    (ra),
        .duty_g    (ga),
        .duty_b    (ba)
    );

    hue_sequencer #(.STEP_DIV(1)) dut_b (
        .clk       (clk),
        .rst       (rst_b),
        .en        (en_b),
`ifdef HUE_SEQ_DIR_EN
        .dir       (dir_b),
`endif
        .out_valid (vb),
        .out_ready (ready_b),
        .duty_r    (rb),
        .duty_g    (gb),
        .duty_b    (bb)
    );

    // Colour at wheel position p (steps from red), from the six-sector table.
    function automatic logic [23:0] model_rgb(input int p);
        int q, s, k;
        logic [7:0] r, g, b;
        q = p % REV;
        s = q / MAXV;
        k = q % MAXV;
        case (s)
            0:       begin r = 8'(MAXV);     g = 8'(k);        b = 8'd0;          end
            1:       begin r = 8'(MAXV - k); g = 8'(MAXV);     b = 8'd0;          end
            2:       begin r = 8'd0;         g = 8'(MAXV);     b = 8'(k);         end
            3:       begin r = 8'd0;         g = 8'(MAXV - k); b = 8'(MAXV);      end
            4:       begin r = 8'(k);        g = 8'd0;         b = 8'(MAXV);      end
            default: begin r = 8'(MAXV);     g = 8'd0;         b = 8'(MAXV - k);  end
        endcase
        return {r, g, b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Free-running A with ready=1: a new triple every 4th cycle, in wheel order.
    task automatic run_a(input int cycles);
        logic exp_v;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            cyc_a++;
            exp_v = (cyc_a % 4 == 0);
            chk("a_valid_phase", {31'd0, va}, {31'd0, exp_v});
            if (exp_v) begin
                pa++;
                chk("a_triple", {8'd0, ra, ga, ba}, {8'd0, model_rgb(pa)});
                if (pa == 1)   chk("a_first_step", {8'd0, ra, ga, ba}, 32'h00FF0100);
                if (pa == 256) chk("a_step256",    {8'd0, ra, ga, ba}, 32'h00FEFF00);
            end
        end
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b1; ready_a = 1'b1;
        rst_b = 1'b1; en_b = 1'b1; ready_b = 1'b1;
        repeat (3) @(negedge clk);

        chk("a_reset_valid",  {31'd0, va}, 32'd0);
        chk("a_reset_triple", {8'd0, ra, ga, ba}, 32'h00FF0000);
        chk("b_reset_valid",  {31'd0, vb}, 32'd0);
        chk("b_reset_triple", {8'd0, rb, gb, bb}, 32'h00FF0000);

        // A: steady stepping, then a 20-cycle downstream stall.
        rst_a = 1'b0;
        run_a(1040);
        ready_a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc_a++;
            chk("a_stall_valid",  {31'd0, va}, 32'd1);
            chk("a_stall_triple", {8'd0, ra, ga, ba}, {8'd0, model_rgb(pa)});
        end
        ready_a = 1'b1;
        @(negedge clk);
        cyc_a++;
        pa++;
        chk("a_unstall_valid",  {31'd0, va}, 32'd1);
        chk("a_unstall_triple", {8'd0, ra, ga, ba}, {8'd0, model_rgb(pa)});
        run_a(41);

        // A: enable low for 100 cycles; phase must resume where it stopped.
        en_a = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("a_en_off_valid", {31'd0, va}, 32'd0);
        end
        en_a = 1'b1;
        run_a(200);

        // B: one full revolution at a step per cycle.
        rst_b  = 1'b0;
        prev_b = 24'hFF0000;
        for (int i = 0; i < REV; i++) begin
            @(negedge clk);
            pb++;
            chk("b_rev_valid",  {31'd0, vb}, 32'd1);
            chk("b_rev_triple", {8'd0, rb, gb, bb}, {8'd0, model_rgb(pb)});
            n_cmp++;
            assert ({rb, gb, bb} !== prev_b) else begin
                n_bad++;
                $error("FAIL b_rev_dup observed=%0h expected!=%0h", {rb, gb, bb}, prev_b);
            end
            prev_b = {rb, gb, bb};
        end
        chk("b_rev_last", {8'd0, rb, gb, bb}, 32'h00FF0000);

        // B: move into S3, stall, then reset mid-stall.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            pb++;
            chk("b_walk_triple", {8'd0, rb, gb, bb}, {8'd0, model_rgb(pb)});
        end
        ready_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("b_s3_stall_valid",  {31'd0, vb}, 32'd1);
            chk("b_s3_stall_triple", {8'd0, rb, gb, bb}, {8'd0, model_rgb(pb)});
        end
        rst_b = 1'b1;
        @(negedge clk);
        chk("b_rst_valid",  {31'd0, vb}, 32'd0);
        chk("b_rst_triple", {8'd0, rb, gb, bb}, 32'h00FF0000);
        rst_b = 1'b0;
        @(negedge clk);
        chk("b_post_rst_valid",  {31'd0, vb}, 32'd1);
        chk("b_post_rst_triple", {8'd0, rb, gb, bb}, 32'h00FF0100);
        @(negedge clk);
        chk("b_post_rst_hold", {8'd0, rb, gb, bb}, 32'h00FF0100);

`ifdef HUE_SEQ_DIR_EN
        // B: backward stepping from reset, then forward again.
        rst_b = 1'b1;
        @(negedge clk);
        rst_b   = 1'b0;
        ready_b = 1'b1;
        dir_b   = 1'b1;
        pb      = REV;
        @(negedge clk);
        pb--;
        chk("b_back1", {8'd0, rb, gb, bb}, {8'd0, model_rgb(pb)});
        chk("b_back1_const", {8'd0, rb, gb, bb}, 32'h00FF0001);
        @(negedge clk);
        pb--;
        chk("b_back2", {8'd0, rb, gb, bb}, {8'd0, model_rgb(pb)});
        dir_b = 1'b0;
        @(negedge clk);
        pb++;
        chk("b_fwd_again", {8'd0, rb, gb, bb}, {8'd0, model_rgb(pb)});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
